ssp_tx_serializer: RTL and testbench

Transmit logic stage directly downstream of the SSP transmit FIFO. Pops one word at a time from the FIFO head and serializes it onto the SSP pins in synchronous-serial frame format. Generates the serial clock, the one-bit-period frame pulse and the output enable. Back-to-back frames are sent with no idle gap while the FIFO holds data.

---
 rtl/ssp_tx_serializer.sv | 148 ++++++++++++++
 tb/tb_ssp_tx_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops words from the TX FIFO head and shifts them out in SSP frame format.
// Optional build macro SSP_TX_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module ssp_tx_serializer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HALF_DIV = 1
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              tmit,
    input  logic [DATA_W-1:0] txdata,
    output logic              remove,
    output logic              sspclkout,
    output logic              sspfssout,
    output logic              ssptxd,
    output logic              sspoe_b,
    output logic              busy
);

    localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                sclk_q, sclk_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                fss_q, fss_d;
    logic                txd_q, txd_d;
    logic                oe_b_q, oe_b_d;
    logic                remove_q, remove_d;
    logic                busy_q, busy_d;

    logic                div_term;
    logic                rise;
    logic [DATA_W-1:0]   shift_nx;
    logic                first_bit;
    logic                next_bit;

    always_comb begin
        div_term = (div_cnt_q == DIV_LAST);
        // A rise event is the divider terminal count while the serial clock is low.
        rise      = div_term && !sclk_q;
        div_cnt_d = div_term ? '0 : div_cnt_q + 1'b1;
        sclk_d    = div_term ? ~sclk_q : sclk_q;

`ifdef SSP_TX_LSB_FIRST_EN
        shift_nx  = shift_q >> 1;
        first_bit = shift_q[0];
        next_bit  = shift_nx[0];
`else
        shift_nx  = shift_q << 1;
        first_bit = shift_q[DATA_W-1];
        next_bit  = shift_nx[DATA_W-1];
`endif

        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        fss_d     = fss_q;
        txd_d     = txd_q;
        oe_b_d    = oe_b_q;
        remove_d  = 1'b0;

        if (rise) begin
            case (state_q)
                IDLE: begin
                    if (tmit) begin
                        shift_d  = txdata;
                        remove_d = 1'b1;
                        fss_d    = 1'b1;
                        oe_b_d   = 1'b0;
                        txd_d    = 1'b0;
                        state_d  = FRAME;
                    end
                end
                FRAME: begin
                    fss_d     = 1'b0;
                    txd_d     = first_bit;
                    bit_cnt_d = CNT_LAST;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        shift_d   = shift_nx;
                        txd_d     = next_bit;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else if (tmit) begin
                        // Back-to-back frame: reload without passing through IDLE, OE stays asserted.
                        shift_d  = txdata;
                        remove_d = 1'b1;
                        fss_d    = 1'b1;
                        txd_d    = 1'b0;
                        state_d  = FRAME;
                    end else begin
                        oe_b_d  = 1'b1;
                        txd_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk) begin
        if (clear) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            fss_q     <= 1'b0;
            txd_q     <= 1'b0;
            oe_b_q    <= 1'b1;
            remove_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            fss_q     <= fss_d;
            txd_q     <= txd_d;
            oe_b_q    <= oe_b_d;
            remove_q  <= remove_d;
            busy_q    <= busy_d;
        end
    end

    assign remove    = remove_q;
    assign sspclkout = sclk_q;
    assign sspfssout = fss_q;
    assign ssptxd    = txd_q;
    assign sspoe_b   = oe_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Scoreboard bench for ssp_tx_serializer: one instance at HALF_DIV=1, one at HALF_DIV=3, each fed by a FIFO model.
module tb_ssp_tx_serializer;

    localparam int HD0 = 1;
    localparam int HD1 = 3;

    logic       pclk = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] tmit = '0;
    logic [7:0] txdata_in [2];
    logic [1:0] remove, sclk, fss, txd, oeb, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] fmem [2][16];
    logic [7:0] emem [2][16];
    int fhead [2], ftail [2], ehead [2], etail [2];

    bit         in_frame [2];
    int         nbits [2];
    logic [7:0] got_w [2];
    int         sclk_run [2], fss_run [2];
    int         rm_cnt [2], rm_last [2], rm_prev [2];
    logic       prev_sclk [2], prev_txd [2], prev_fss [2], prev_rm [2];

    always #5 pclk = ~pclk;

    ssp_tx_serializer #(.DATA_W(8), .HALF_DIV(HD0)) u_dut0 (
        .pclk(pclk), .clear(clear), .tmit(tmit[0]), .txdata(txdata_in[0]),
        .remove(remove[0]), .sspclkout(sclk[0]), .sspfssout(fss[0]),
        .ssptxd(txd[0]), .sspoe_b(oeb[0]), .busy(busy[0])
    );

    ssp_tx_serializer #(.DATA_W(8), .HALF_DIV(HD1)) u_dut1 (
        .pclk(pclk), .clear(clear), .tmit(tmit[1]), .txdata(txdata_in[1]),
        .remove(remove[1]), .sspclkout(sclk[1]), .sspfssout(fss[1]),
        .ssptxd(txd[1]), .sspoe_b(oeb[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hd_of(input int i);
        return (i == 0) ? HD0 : HD1;
    endfunction

    task automatic push_word(input int i, input logic [7:0] w);
        fmem[i][ftail[i] % 16] = w;
        ftail[i]++;
        emem[i][etail[i] % 16] = w;
        etail[i]++;
    endtask

    // Monitor and FIFO model: samples 1 time unit after each rising pclk edge.
    initial begin
        logic clr_s;
        txdata_in[0] = '0;
        txdata_in[1] = '0;
        forever begin
            @(posedge pclk);
            clr_s = clear;
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (clr_s) begin
                    check("rst_sclk", sclk[i], 0);
                    check("rst_fss", fss[i], 0);
                    check("rst_txd", txd[i], 0);
                    check("rst_oeb", oeb[i], 1);
                    check("rst_remove", remove[i], 0);
                    check("rst_busy", busy[i], 0);
                    in_frame[i] = 0;
                    nbits[i]    = 0;
                    sclk_run[i] = 1;
                    fss_run[i]  = 0;
                    ehead[i]    = etail[i];
                end else begin
                    if (sclk[i] !== prev_sclk[i]) begin
                        check("sclk_half", sclk_run[i], hd_of(i));
                        sclk_run[i] = 1;
                    end else begin
                        sclk_run[i]++;
                    end

                    if (fss[i] === 1'b1) begin
                        fss_run[i]++;
                    end else if (fss_run[i] > 0) begin
                        check("fss_len", fss_run[i], 2 * hd_of(i));
                        fss_run[i] = 0;
                    end

                    if (remove[i] === 1'b1) begin
                        check("rm_on_rise", {prev_sclk[i], sclk[i]}, 2'b01);
                        check("rm_pulse", prev_rm[i], 0);
                        check("rm_tmit", (ftail[i] != fhead[i]), 1);
                        if (ftail[i] != fhead[i]) fhead[i]++;
                        rm_prev[i] = rm_last[i];
                        rm_last[i] = cyc;
                        rm_cnt[i]++;
                    end

                    if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b0) begin
                        check("txd_stable", txd[i], prev_txd[i]);
                        check("fss_stable", fss[i], prev_fss[i]);
                        if (fss[i] === 1'b1) begin
                            check("fs_txd", txd[i], 0);
                            check("fs_oeb", oeb[i], 0);
                            check("fs_busy", busy[i], 1);
                            in_frame[i] = 1;
                            nbits[i]    = 0;
                            got_w[i]    = '0;
                        end else if (in_frame[i]) begin
                            check("bit_oeb", oeb[i], 0);
`ifdef SSP_TX_LSB_FIRST_EN
                            got_w[i][nbits[i]] = txd[i];
`else
                            got_w[i][7 - nbits[i]] = txd[i];
`endif
                            nbits[i]++;
                            if (nbits[i] == 8) begin
                                in_frame[i] = 0;
                                if (ehead[i] != etail[i]) begin
                                    check("word", got_w[i], emem[i][ehead[i] % 16]);
                                    ehead[i]++;
                                end else begin
                                    check("sb_underrun", etail[i] - ehead[i], 1);
                                end
                            end
                        end
                    end
                end
                prev_sclk[i] = sclk[i];
                prev_txd[i]  = txd[i];
                prev_fss[i]  = fss[i];
                prev_rm[i]   = remove[i];
                tmit[i]      = (ftail[i] != fhead[i]);
                txdata_in[i] = fmem[i][fhead[i] % 16];
            end
        end
    end

    task automatic wait_done(input int i);
        int n = 0;
        while ((ehead[i] != etail[i] || ftail[i] != fhead[i] || busy[i] !== 1'b0) && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 3000) check("wait_done_timeout", n, 0);
        repeat (2) @(negedge pclk);
        check("idle_oeb", oeb[i], 1);
        check("idle_busy", busy[i], 0);
        check("idle_fss", fss[i], 0);
        check("idle_txd", txd[i], 0);
    endtask

    initial begin
        int c0, c1, n;
        repeat (3) @(posedge pclk);
        @(negedge pclk) clear = 1'b0;

        // Idle with empty FIFO
        repeat (40) begin
            @(negedge pclk);
            check("t1_remove", remove[0], 0);
            check("t1_oeb", oeb[0], 1);
            check("t1_fss", fss[0], 0);
        end

        // Single word then idle
        c0 = rm_cnt[0];
        push_word(0, 8'hA5);
        wait_done(0);
        check("t2_pops", rm_cnt[0] - c0, 1);

        // Back-to-back frames
        c0 = rm_cnt[0];
        push_word(0, 8'h81);
        push_word(0, 8'h7E);
        wait_done(0);
        check("t3_pops", rm_cnt[0] - c0, 2);
        check("t3_gap", rm_last[0] - rm_prev[0], 2 * HD0 * 9);

        // Mid-frame clear drops the word
        push_word(0, 8'hFF);
        n = 0;
        while (!(in_frame[0] && nbits[0] == 4) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 500) check("t4_wait_bit3", n, 0);
        clear = 1'b1;
        @(negedge pclk) clear = 1'b0;
        c0 = rm_cnt[0];
        repeat (20) @(negedge pclk);
        check("t4_no_pop", rm_cnt[0] - c0, 0);
        check("t4_oeb", oeb[0], 1);
        check("t4_busy", busy[0], 0);
        push_word(0, 8'h5A);
        wait_done(0);
        check("t4_restart_pops", rm_cnt[0] - c0, 1);

        // Slower serial clock, back-to-back
        c1 = rm_cnt[1];
        push_word(1, 8'h3C);
        push_word(1, 8'hC3);
        wait_done(1);
        check("t5_pops", rm_cnt[1] - c1, 2);
        check("t5_gap", rm_last[1] - rm_prev[1], 2 * HD1 * 9);

        // Bit-order patterns
        push_word(0, 8'h01);
        push_word(0, 8'h80);
        push_word(0, 8'h00);
        push_word(0, 8'hFF);
        push_word(0, 8'h96);
        wait_done(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
